// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the sequencer state encoding, the register-index width and the NOP encoding.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam int REG_IDX_W = 5;

  // addi x0, x0, 0 -- what a bubble in ID/EX decodes as
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: fixed-priority resolution of memory waits, load-use
// hazards and taken-branch flushes, with a memory-wait watchdog and saturating perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 IDEX_MemRead_i,
  input  logic [REG_IDX_W-1:0] IDEX_Rd_i,
  input  logic [REG_IDX_W-1:0] IFID_Rs1_i,
  input  logic [REG_IDX_W-1:0] IFID_Rs2_i,
  input  logic                 Branch_taken_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ack_i,
  output logic                 PC_Write_o,
  output logic                 IFID_Write_o,
  output logic                 IFID_Flush_o,
  output logic                 IDEX_Bubble_o,
  output logic                 mem_stall_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_stall, load_use;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  assign mem_stall = ((state_q == ST_RUN) && dmem_req_i && !dmem_ack_i) ||
                     ((state_q == ST_MEM_WAIT) && !dmem_ack_i);

  assign load_use = IDEX_MemRead_i && (IDEX_Rd_i != '0) &&
                    ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

  // Output decode, highest priority first: ERR, mem stall, load-use, branch, normal
  always_comb begin
    PC_Write_o    = 1'b0;
    IFID_Write_o  = 1'b0;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    mem_stall_o   = 1'b0;
    err_o         = 1'b0;
    if (!rst_i) begin
      if (state_q == ST_ERR) begin
        mem_stall_o = 1'b1;
        err_o       = 1'b1;
      end else if (mem_stall) begin
        mem_stall_o = 1'b1;
      end else if (load_use) begin
        IDEX_Bubble_o = 1'b1;
      end else begin
        PC_Write_o   = 1'b1;
        IFID_Write_o = 1'b1;
        IFID_Flush_o = Branch_taken_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (mem_stall_o | IDEX_Bubble_o),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (IFID_Flush_o),
    .cnt_o (flush_cnt)
  );

  assign stall_cnt_o = rst_i ? '0 : stall_cnt;
  assign flush_cnt_o = rst_i ? '0 : flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline: generates the PC write enable, IF/ID write enable and flush, ID/EX bubble, and the global memory-stall freeze. It resolves load-use hazards, taken-branch flushes and data-memory wait cycles under a fixed priority, guards memory waits with a watchdog timeout, and keeps saturating performance counters. Sits beside the hazard path in ID, consuming ID/EX and MEM-stage status.

## Interface
- TIMEOUT, 64: max consecutive MEM_WAIT cycles before error (≥2)
- CNT_W, 32: perf counter width
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_Rd_i  in  5  destination register of instruction in EX
- IFID_Rs1_i  in  5  rs1 of instruction in ID
- IFID_Rs2_i  in  5  rs2 of instruction in ID
- Branch_taken_i  in  1  branch in ID resolved taken
- dmem_req_i  in  1  MEM stage issues a data access this cycle
- dmem_ack_i  in  1  data memory completes access this cycle
- PC_Write_o  out  1  PC update enable
- IFID_Write_o  out  1  IF/ID register write enable
- IFID_Flush_o  out  1  zero IF/ID contents
- IDEX_Bubble_o  out  1  insert NOP into ID/EX
- mem_stall_o  out  1  freeze all pipeline registers
- err_o  out  1  sticky watchdog error
- stall_cnt_o  out  CNT_W  cycles with any stall (mem or load-use)
- flush_cnt_o  out  CNT_W  flushes issued

## Operation
- States: RUN, MEM_WAIT, ERR. Reset → RUN, wait_cnt=0, err_o=0, counters=0.
- Outputs are combinational from state and inputs; while rst_i=1 all outputs forced 0.
- Priority per cycle: ERR > mem stall > load-use > branch flush > normal.
- Mem stall: asserted when (state=RUN and dmem_req_i and !dmem_ack_i) or (state=MEM_WAIT and !dmem_ack_i). Drives mem_stall_o=1, PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0.
- RUN → MEM_WAIT on mem stall condition; wait_cnt←1.
- MEM_WAIT: on dmem_ack_i → RUN, stall drops same cycle; else wait_cnt+1; if wait_cnt=TIMEOUT-1 and !dmem_ack_i → ERR.
- ERR: mem_stall_o=1, all enables 0, err_o=1; exits only on rst_i.
- Load-use (no mem stall): IDEX_MemRead_i and IDEX_Rd_i≠0 and (IDEX_Rd_i=IFID_Rs1_i or IDEX_Rd_i=IFID_Rs2_i) → PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0 (branch suppressed; reevaluated next cycle).
- Branch flush (no stall, no load-use): Branch_taken_i → IFID_Flush_o=1, PC_Write_o=1, IFID_Write_o=1.
- Normal: PC_Write_o=1, IFID_Write_o=1, others 0.
- stall_cnt_o +1 each cycle mem_stall_o or IDEX_Bubble_o is 1 (ERR included); flush_cnt_o +1 each cycle IFID_Flush_o=1; both saturate at all-ones.

## Timing
- Zero-latency control: enables reflect inputs in the same cycle; state, wait_cnt, counters update on clk_i rising edge.
- dmem_req_i with dmem_ack_i in same RUN cycle: no stall, stay RUN.
- Ack on the TIMEOUT-1 wait cycle: → RUN, no error.
- Branch_taken_i during mem stall: ignored; pipeline frozen so ID re-presents it after release.
- rst_i mid MEM_WAIT or ERR: next cycle RUN, counters 0, err_o 0.

## Structure
- Shared package: state enum (RUN, MEM_WAIT, ERR), register-index width (5), NOP encoding constant.
- One natural sub-module: sat_counter (CNT_W, inc, sync clear), instantiated twice.

## Test plan
- Reset then idle inputs → PC_Write_o=1, IFID_Write_o=1, all others 0, counters 0.
- IDEX_MemRead_i=1, IDEX_Rd_i=5, IFID_Rs2_i=5 one cycle → PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, stall_cnt_o=1; Rd=0 same case → no bubble.
- dmem_req_i=1, ack after 3 cycles → mem_stall_o=1 for exactly 3 cycles, drops on ack cycle, stall_cnt_o=3, state RUN.
- TIMEOUT=4, dmem_req_i=1, no ack → ERR after 4 stall cycles, err_o=1 sticky, enables 0; rst_i one cycle → RUN, err_o=0.
- Branch_taken_i with load-use hazard → bubble, no flush; next cycle hazard cleared → IFID_Flush_o=1, flush_cnt_o=1.
- Counter forced near all-ones (CNT_W=4) with continuous stall → saturates at 15.
